// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// datapath mux selects, instruction classes and fault causes.
package multicycle_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5,
      ST_FAULT     = 3'd6
   } state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Select encodings are shared with the datapath muxes; do not renumber.
   localparam logic [1:0] PC_SRC_4   = 2'd0;
   localparam logic [1:0] PC_SRC_IMM = 2'd1;
   localparam logic [1:0] PC_SRC_ALU = 2'd2;

   localparam logic [1:0] ORIG_MEM = 2'd0;
   localparam logic [1:0] ORIG_ALU = 2'd1;
   localparam logic [1:0] ORIG_PC4 = 2'd2;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_ILLEGAL = 2'd1,
      CAUSE_TIMEOUT = 2'd2
   } fault_cause_e;

   typedef enum logic [3:0] {
      CLS_ILLEGAL,
      CLS_LOAD,
      CLS_STORE,
      CLS_OP,
      CLS_OP_IMM,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_LUI,
      CLS_AUIPC,
      CLS_SYSTEM
   } op_class_e;

   function automatic logic is_mem_class(input op_class_e cls);
      return (cls == CLS_LOAD) || (cls == CLS_STORE);
   endfunction

endpackage

// File: rtl/multicycle_sequencer_opcode_class.sv
// Combinational opcode -> instruction-class decoder, also usable by datapath control.
module multicycle_sequencer_opcode_class
   import multicycle_sequencer_pkg::*;
(
   input  logic [6:0] opcode_i,
   output op_class_e  class_o,
   output logic       legal_o
);

   // NOTE: every output gets a default before the case, so no path can infer a latch.
   always_comb begin
      class_o = CLS_ILLEGAL;
      unique case (opcode_i)
         OPC_LOAD:   class_o = CLS_LOAD;
         OPC_STORE:  class_o = CLS_STORE;
         OPC_OP:     class_o = CLS_OP;
         OPC_OP_IMM: class_o = CLS_OP_IMM;
         OPC_BRANCH: class_o = CLS_BRANCH;
         OPC_JAL:    class_o = CLS_JAL;
         OPC_JALR:   class_o = CLS_JALR;
         OPC_LUI:    class_o = CLS_LUI;
         OPC_AUIPC:  class_o = CLS_AUIPC;
         OPC_SYSTEM: class_o = CLS_SYSTEM;
         default:    class_o = CLS_ILLEGAL;
      endcase
   end

   assign legal_o = (class_o != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for an RV32I datapath sharing one memory port between
// instruction fetch and load/store, with memory timeout and retired-instruction count.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_sel_data,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic [1:0]  wd_src,
   output logic        retire,
   output logic [31:0] instret,
   output logic        halted,
   output logic        fault,
   output logic [1:0]  fault_cause
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   state_e             state_q, state_d;
   op_class_e          class_q, class_d;
   fault_cause_e       cause_q, cause_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [31:0]        instret_q, instret_d;

   op_class_e          dec_class;
   logic               dec_legal;
   logic               timeout_hit;

   multicycle_sequencer_opcode_class u_opcode_class (
      .opcode_i (opcode),
      .class_o  (dec_class),
      .legal_o  (dec_legal)
   );

   // A timeout of zero never fires; the counter then stays pinned at zero.
   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_MAX);

   always_comb begin
      state_d      = state_q;
      class_d      = class_q;
      cause_d      = cause_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_sel_data = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_SRC_4;
      reg_write    = 1'b0;
      wd_src       = ORIG_ALU;
      retire       = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = ST_DECODE;
            end else if (timeout_hit) begin
               state_d = ST_FAULT;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_DECODE: begin
            class_d = dec_class;
            if (dec_class == CLS_SYSTEM) begin
               state_d = ST_HALT;
            end else if (dec_legal) begin
               state_d = ST_EXECUTE;
            end else begin
               state_d = ST_FAULT;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         ST_EXECUTE: begin
            if (class_q == CLS_BRANCH) begin
               pc_write = 1'b1;
               pc_src   = branch_taken ? PC_SRC_IMM : PC_SRC_4;
               retire   = 1'b1;
               state_d  = ST_FETCH;
            end else if (is_mem_class(class_q)) begin
               state_d = ST_MEMORY;
            end else begin
               state_d = ST_WRITEBACK;
            end
         end
         ST_MEMORY: begin
            mem_req      = 1'b1;
            mem_sel_data = 1'b1;
            mem_we       = (class_q == CLS_STORE);
            if (mem_ready) begin
               if (class_q == CLS_STORE) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_d  = ST_FETCH;
               end else begin
                  state_d = ST_WRITEBACK;
               end
            end else if (timeout_hit) begin
               state_d = ST_FAULT;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_WRITEBACK: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retire    = 1'b1;
            state_d   = ST_FETCH;
            unique case (class_q)
               CLS_LOAD:          wd_src = ORIG_MEM;
               CLS_JAL, CLS_JALR: wd_src = ORIG_PC4;
               default:           wd_src = ORIG_ALU;
            endcase
            unique case (class_q)
               CLS_JAL:  pc_src = PC_SRC_IMM;
               CLS_JALR: pc_src = PC_SRC_ALU;
               default:  pc_src = PC_SRC_4;
            endcase
         end
         default: ;
      endcase

      // Reset dominates the handshake: nothing is written or retired this cycle.
      if (reset) begin
         mem_req      = 1'b0;
         mem_we       = 1'b0;
         mem_sel_data = 1'b0;
         ir_write     = 1'b0;
         pc_write     = 1'b0;
         reg_write    = 1'b0;
         retire       = 1'b0;
      end
   end

   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (mem_req && !mem_ready && (wait_q != WAIT_MAX)) begin
         wait_d = wait_q + 1'b1;
      end
   end

   assign instret_d = instret_q + {31'd0, retire};

   // NOTE: non-blocking assignments so every register samples the pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         class_q   <= CLS_ILLEGAL;
         cause_q   <= CAUSE_NONE;
         wait_q    <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         cause_q   <= cause_d;
         wait_q    <= wait_d;
         instret_q <= instret_d;
      end
   end

   assign instret     = instret_q;
   assign halted      = (state_q == ST_HALT);
   assign fault       = (state_q == ST_FAULT);
   assign fault_cause = cause_q;

endmodule
